// File: rtl/axis_round_robin_mux_pkg.sv
// Shared helpers for the stream blocks: ceiling log2, channel-index width
// derivation, the arbiter state encoding and the arbiter control struct.
package axis_round_robin_mux_pkg;

   // Ceiling log2; clog2(1) is 0, clog2(5) is 3.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

   // Width of a channel index; never narrower than one bit.
   function automatic int chan_bits(input int channels);
      return (channels < 2) ? 1 : clog2(channels);
   endfunction

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Per-cycle arbiter control, grouped so checkers can bind to one signal.
   typedef struct packed {
      state_t state;     // current arbiter state
      logic   out_free;  // output register can take a beat this cycle
      logic   accept;    // beat moves from the granted source this cycle
      logic   rel;       // grant ends at this clock edge
   } mux_ctl_t;

endpackage

// File: rtl/axis_round_robin_mux_picker.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping
// explicitly at CHANNELS so non-power-of-two channel counts work.
module round_robin_picker
   import axis_round_robin_mux_pkg::*;
#(
   parameter int CHANNELS = 4,
   localparam int CHAN_BITS = chan_bits(CHANNELS)
) (
   input  logic [CHANNELS-1:0]  req,
   input  logic [CHAN_BITS-1:0] ptr,
   output logic                 found,
   output logic [CHAN_BITS-1:0] idx
);

   localparam logic [CHAN_BITS:0] CHANNELS_W = (CHAN_BITS+1)'(CHANNELS);

   logic [CHAN_BITS:0] cand;

   // Walk ptr, ptr+1, ... modulo CHANNELS and keep the first hit.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cand = {1'b0, ptr} + (CHAN_BITS+1)'(i);
         if (cand >= CHANNELS_W) begin
            cand = cand - CHANNELS_W;
         end
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand[CHAN_BITS-1:0];
         end
      end
   end

endmodule

// File: rtl/axis_round_robin_mux.sv
// Round-robin AXI-stream merge with a bounded burst per grant, a registered
// output stage and a sticky per-channel overflow mask.
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both high at the rising clock edge; valid never waits on ready, and a
// raised valid with its data holds until that transfer happens.
module axis_round_robin_mux
   import axis_round_robin_mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int BURST    = 4,
   localparam int CHAN_BITS = chan_bits(CHANNELS)
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [CHANNELS*WIDTH-1:0] idata,
   input  logic [CHANNELS-1:0]       ivalid,
   output logic [CHANNELS-1:0]       iready,
   input  logic [CHANNELS-1:0]       ioverflow,
   output logic [WIDTH-1:0]          odata,
   output logic [CHAN_BITS-1:0]      ochan,
   output logic                      ovalid,
   input  logic                      oready,
   output logic [CHANNELS-1:0]       overflow
);

   localparam int                   N_BITS  = clog2(BURST + 1);
   localparam logic [N_BITS-1:0]    LAST_N  = N_BITS'(BURST - 1);
   localparam logic [N_BITS-1:0]    ONE_N   = N_BITS'(1);
   localparam logic [CHAN_BITS-1:0] LAST_CH = CHAN_BITS'(CHANNELS - 1);
   localparam logic [CHAN_BITS-1:0] ONE_CH  = CHAN_BITS'(1);

   state_t               state, state_nx;
   logic [CHAN_BITS-1:0] g, g_nx;
   logic [CHAN_BITS-1:0] p, p_nx;
   logic [N_BITS-1:0]    n, n_nx;

   logic                 pick_found;
   logic [CHAN_BITS-1:0] pick_idx;

   logic [WIDTH-1:0]     chan_data [CHANNELS];
   logic [WIDTH-1:0]     sel_data;
   logic                 sel_valid;

   mux_ctl_t             ctl;

   // Unpack the flat data bus into one word per channel.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
      assign chan_data[c] = idata[c*WIDTH +: WIDTH];
   end

   round_robin_picker #(
      .CHANNELS (CHANNELS)
   ) u_picker (
      .req   (ivalid),
      .ptr   (p),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Select the granted source.
   always_comb begin
      sel_data  = chan_data[g];
      sel_valid = ivalid[g];
   end

   // Per-cycle control: a release happens on the last beat of a burst or
   // when the granted source is empty while it is being offered ready.
   always_comb begin
      ctl.state    = state;
      ctl.out_free = !ovalid || oready;
      ctl.accept   = (state == GRANT) && sel_valid && ctl.out_free;
      ctl.rel      = (state == GRANT) && ctl.out_free
                     && (!sel_valid || (n == LAST_N));
   end

   // Only the granted channel sees ready, and only when the output can move.
   always_comb begin
      iready = '0;
      if ((ctl.state == GRANT) && ctl.out_free) begin
         iready[g] = 1'b1;
      end
   end

   // Next-state logic for the arbiter and its grant/pointer/beat counters.
   always_comb begin
      state_nx = ctl.state;
      g_nx     = g;
      p_nx     = p;
      n_nx     = n;
      case (ctl.state)
         IDLE: begin
            if (pick_found) begin
               state_nx = GRANT;
               g_nx     = pick_idx;
               n_nx     = '0;
            end
         end
         GRANT: begin
            if (ctl.accept) begin
               n_nx = n + ONE_N;
            end
            if (ctl.rel) begin
               state_nx = IDLE;
               // The released channel is searched last next time.
               p_nx     = (g == LAST_CH) ? '0 : g + ONE_CH;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         g     <= '0;
         p     <= '0;
         n     <= '0;
      end else begin
         state <= state_nx;
         g     <= g_nx;
         p     <= p_nx;
         n     <= n_nx;
      end
   end

   // Output register: load on accept, drop valid once consumed, else hold.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         odata  <= '0;
         ochan  <= '0;
         ovalid <= 1'b0;
      end else if (ctl.accept) begin
         odata  <= sel_data;
         ochan  <= g;
         ovalid <= 1'b1;
      end else if (oready) begin
         ovalid <= 1'b0;
      end
   end

   // Sticky overflow mask, cleared only by reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         overflow <= '0;
      end else begin
         overflow <= overflow | ioverflow;
      end
   end

endmodule

// File: doc/axis_round_robin_mux.md
# axis_round_robin_mux

Merges CHANNELS AXI-stream sources into one registered AXI-stream output with round-robin arbitration and a bounded burst length per grant. It sits behind a bank of push-to-stream FIFOs, one per capture source, and drains them fairly toward a single consumer such as a UART or USB packetizer. It also aggregates the FIFOs' sticky overflow flags so the consumer can tag lost data by channel.

## Interface
- WIDTH, 8: data bits per beat.
- CHANNELS, 4: number of input streams, 2..16.
- BURST, 4: maximum beats accepted per grant, at least 1.
- CHAN_BITS, clog2(CHANNELS): width of the channel index; derived, not overridden.

- clock  in  1  single clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- idata  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- ivalid  in  CHANNELS  per-channel valid.
- iready  out  CHANNELS  per-channel ready; at most one bit is high in any cycle.
- ioverflow  in  CHANNELS  per-channel overflow flags from the sources.
- odata  out  WIDTH  registered output beat.
- ochan  out  CHAN_BITS  index of the source of the current odata.
- ovalid  out  1  output valid.
- oready  in  1  output ready.
- overflow  out  CHANNELS  sticky overflow mask.

## Operation
- State machine states: IDLE and GRANT. Registers: grant index g, next-search pointer p, beat count n (clog2(BURST+1) bits), and the output register (odata, ochan, ovalid).
- IDLE:
  - If any ivalid is high, choose the first channel c with ivalid[c] set, searching p, p+1, ... modulo CHANNELS.
  - Then set g=c and n=0, and go to GRANT.
  - If no ivalid is high, stay in IDLE.
  - All iready bits are low in IDLE.
- GRANT:
  - iready[g] = !ovalid || oready. All other iready bits are 0.
  - A beat is accepted when ivalid[g] && iready[g]. On accept: odata<=idata[g], ochan<=g, ovalid<=1, n<=n+1.
  - Release when either condition holds:
    - a beat is accepted with n==BURST-1;
    - ivalid[g]==0 while iready[g]==1, meaning the source is empty.
  - On release: go to IDLE and set p = (g+1) mod CHANNELS, with explicit wrap for CHANNELS that are not a power of two.
  - If the output stalls (iready[g]==0), stay in GRANT and count nothing.
- Output register: ovalid<=0 when oready && no accept. odata and ochan hold while ovalid && !oready (AXI-stream stability).
- overflow[c] <= overflow[c] | ioverflow[c] every cycle. It is cleared only by reset.
- Reset values: state IDLE, g=0, p=0, n=0, odata=0, ochan=0, ovalid=0, overflow=0, iready=0.
- Reset asserted mid-burst drops the output beat and the grant immediately. A beat already accepted from a source is lost; the source FIFO is reset by the same resetn.

## Timing
- Arbitration latency: ivalid seen in IDLE at cycle N gives GRANT at N+1, iready[g] high at N+1, and the first beat on odata at N+2.
- Throughput inside a grant: 1 beat/cycle while oready stays high.
- Each release costs exactly one IDLE bubble cycle.
- Full rate across k continuously busy channels is BURST/(BURST+1).
- Fairness: a channel continuously valid waits at most (CHANNELS-1)*(BURST+1) cycles between grants, assuming oready is always high.
- Simultaneous release and new ivalid on the same channel: that channel is searched last, because p has moved past it.
- BURST=1: every accepted beat releases the grant.
- n never exceeds BURST-1 at the start of a beat.
- overflow has one-cycle latency from ioverflow.

## Structure
- The shared package holds the clog2 function and the channel-index width derivation; other stream blocks use them too.
- Sub-module round_robin_picker is natural:
  - purely combinational;
  - inputs: request vector and pointer;
  - outputs: found flag and index.
- The FSM, counters and output register stay in axis_round_robin_mux.

## Test plan
- Reset, then ivalid=0 on all channels -> ovalid=0, iready=0000 and overflow=0000 hold indefinitely.
- Single source: ch2 holds 6 beats 0x10..0x15, BURST=4, oready=1 -> ch2 is granted twice. Output is 0x10..0x13 with ochan=2, then one bubble cycle, then 0x14,0x15.
- All 4 channels always valid, oready=1 -> grant order 0,1,2,3,0,... with 4 beats each. The bubble falls every 5th cycle and there are no duplicate or dropped beats.
- Backpressure: oready toggling 1,0,0,1 during a burst -> odata/ochan stay stable while stalled, iready[g] is low on stall cycles, and beat order is preserved.
- Early release: ch1 provides 2 beats then drops ivalid, ch3 is valid -> ch1 is released after 2 beats, and ch3 is granted next.
- ioverflow[3] pulsed for 1 cycle -> overflow=1000 from the next cycle until resetn is asserted mid-burst. Reset clears overflow, ovalid and the grant, and the next grant starts at ch0.
